// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract engine: one shared N-bit ripple-carry adder is
// stepped over CHUNKS operand slices, LSB slice first, with the carry held in
// a register between slices. Requests and results use valid/ready handshakes.

// Plain N-bit ripple-carry adder; the only adder on the sequencer datapath.
module ripple_carry_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Carry ripples from bit 0 upward through a full-adder per bit.
  always_comb begin : carry_chain
    logic c;
    // NOTE: blocking assignments are required in combinational logic so that
    // each bit sees the carry produced by the bit below it in this same pass;
    // clocked state uses non-blocking assignments instead.
    c   = cin;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

module multiword_add_sequencer #(
  parameter int N      = 4,
  parameter int CHUNKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*CHUNKS-1:0]   in_a,
  input  logic [N*CHUNKS-1:0]   in_b,
  input  logic                  in_sub,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*CHUNKS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int W  = N * CHUNKS;
  localparam int KW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [31:0]   shamt;
  logic [W-1:0]  chunk_mask;
  logic [N-1:0]  add_a, add_b, add_sum;
  logic          add_cout;

  // Slice selection: shift the active chunk down to bit 0 for the adder and
  // build a mask that places the adder result back into the same slice.
  always_comb begin
    shamt      = 32'(k_q) * 32'(N);
    add_a      = N'(a_q >> shamt);
    add_b      = N'(b_q >> shamt);
    chunk_mask = W'({N{1'b1}}) << shamt;
  end

  ripple_carry_adder #(.N(N)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    // NOTE: every signal gets its hold value first so that no path through
    // the case statement leaves one unassigned, which would infer a latch.
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + ~borrow, so invert B and the borrow once
          // at capture; the RUN phase is then a pure addition.
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub ^ in_cin;
          k_d     = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        sum_d   = (sum_q & ~chunk_mask) | (W'(add_sum) << shamt);
        carry_d = add_cout;
        if (k_q == K_LAST) begin
          cout_d  = add_cout;
          // Signed overflow: equal operand signs but a result sign that
          // differs; b_q already holds the inverted operand for subtraction.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[N-1] != a_q[W-1]);
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake and status outputs decode from state only.
  always_comb begin
    in_ready  = rst_n && (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    out_sum   = sum_q;
    out_cout  = cout_q;
    out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed and randomized checks of multiword_add_sequencer against an
// integer-arithmetic reference model, for CHUNKS=4 and CHUNKS=1 instances.
module tb_multiword_add_sequencer;

  localparam int N   = 4;
  localparam int CH  = 4;
  localparam int W   = N * CH;
  localparam int CH1 = 1;
  localparam int W1  = N * CH1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         in_valid0 = 1'b0;
  logic         in_valid1 = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         in_cin = 1'b0;
  logic         out_ready = 1'b1;

  logic          in_ready0, out_valid0, out_cout0, out_ovf0, busy0;
  logic [W-1:0]  out_sum0;
  logic          in_ready1, out_valid1, out_cout1, out_ovf1, busy1;
  logic [W1-1:0] out_sum1;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  multiword_add_sequencer #(.N(N), .CHUNKS(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_sum   (out_sum0),
    .out_cout  (out_cout0),
    .out_ovf   (out_ovf0),
    .busy      (busy0)
  );

  multiword_add_sequencer #(.N(N), .CHUNKS(CH1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_a      (in_a[W1-1:0]),
    .in_b      (in_b[W1-1:0]),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_sum   (out_sum1),
    .out_cout  (out_cout1),
    .out_ovf   (out_ovf1),
    .busy      (busy1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic on a w-bit operand pair.
  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic cin);
    longint span, half, ua, ub, sa, sb, c, full, sr;
    res_t   r;
    span = longint'(1) << w;
    half = span / 2;
    ua   = longint'(a) & (span - 1);
    ub   = longint'(b) & (span - 1);
    sa   = (ua >= half) ? ua - span : ua;
    sb   = (ub >= half) ? ub - span : ub;
    c    = longint'(cin);
    if (sub) begin
      full   = ua - ub - c;
      sr     = sa - sb - c;
      r.cout = (full >= 0);
    end else begin
      full   = ua + ub + c;
      sr     = sa + sb + c;
      r.cout = (full >= span);
    end
    r.sum = 16'(full & (span - 1));
    r.ovf = (sr >= half) || (sr < -half);
    return r;
  endfunction

  // One directed operation on the CHUNKS=4 instance with explicit expectations.
  // Called at posedge+1 with the block idle and out_ready high.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic cin,
                       input logic [15:0] e_sum, input logic e_cout, input logic e_ovf);
    int lat;
    check({tag, ".in_ready"}, in_ready0, 1);
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid0 = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after the accepting edge; they must be ignored.
    in_valid0 = 1'b0; in_a = ~a; in_b = ~b; in_sub = ~sub; in_cin = ~cin;
    lat = 0;
    while (!out_valid0 && lat < 20) begin
      check({tag, ".busy_run"}, busy0, 1);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, CH);
    check({tag, ".busy_done"}, busy0, 1);
    check({tag, ".sum"}, out_sum0, e_sum);
    check({tag, ".cout"}, out_cout0, e_cout);
    check({tag, ".ovf"}, out_ovf0, e_ovf);
    @(posedge clk); #1;
    check({tag, ".valid_drop"}, out_valid0, 0);
    check({tag, ".ready_back"}, in_ready0, 1);
  endtask

  task automatic new_operands();
    in_a   = 16'($urandom);
    in_b   = 16'($urandom);
    in_sub = 1'($urandom);
    in_cin = 1'($urandom);
  endtask

  // Back-to-back random operations with in_valid and out_ready held high.
  task automatic stream(input bit which, input int n_ops);
    res_t        exp_q[$];
    int          acc_q[$];
    int          w, lat, per, cyc, last_acc, n_acc, n_done, a0;
    logic        rdy, vld, ov, co, of;
    logic [15:0] s;
    res_t        e;
    bit          acc;
    w   = which ? W1 : W;
    lat = which ? CH1 : CH;
    per = lat + 2;
    cyc = 0; last_acc = -1; n_acc = 0; n_done = 0;
    out_ready = 1'b1;
    new_operands();
    if (which) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    while (n_done < n_ops && cyc < n_ops * (per + 2) + 50) begin
      rdy = which ? in_ready1  : in_ready0;
      vld = which ? in_valid1  : in_valid0;
      ov  = which ? out_valid1 : out_valid0;
      s   = which ? 16'(out_sum1) : out_sum0;
      co  = which ? out_cout1  : out_cout0;
      of  = which ? out_ovf1   : out_ovf0;
      acc = rdy && vld;
      if (acc) begin
        exp_q.push_back(model(w, in_a, in_b, in_sub, in_cin));
        acc_q.push_back(cyc);
        if (last_acc >= 0) check("stream.period", cyc - last_acc, per);
        last_acc = cyc;
        n_acc++;
      end
      if (ov) begin
        if (exp_q.size() == 0) begin
          check("stream.spurious_valid", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          a0 = acc_q.pop_front();
          // Accept is sampled one cycle before the accepting edge.
          check("stream.latency", cyc - a0, lat + 1);
          check("stream.sum", s, e.sum);
          check("stream.cout", co, e.cout);
          check("stream.ovf", of, e.ovf);
          n_done++;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (n_acc == n_ops) begin
          in_valid0 = 1'b0; in_valid1 = 1'b0;
        end else begin
          new_operands();
        end
      end
    end
    check("stream.ops_done", n_done, n_ops);
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    res_t e;
    int   lat;
    logic [15:0] held;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", out_valid0, 0);
    check("rst.busy", busy0, 0);
    check("rst.sum", out_sum0, 0);
    check("rst.cout", out_cout0, 0);
    check("rst.ovf", out_ovf0, 0);
    check("rst.in_ready_low", in_ready0, 0);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready_high", in_ready0, 1);
    @(posedge clk); #1;

    // Directed add and subtract cases.
    do_op("add_ff_1",    16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("add_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("add_cin",     16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1235, 1'b0, 1'b0);
    do_op("sub_neg",     16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf",     16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    do_op("sub_borrow",  16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

    // Backpressure in DONE.
    e = model(W, 16'hA5A5, 16'h5A5B, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_a = 16'hA5A5; in_b = 16'h5A5B; in_sub = 1'b0; in_cin = 1'b0; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    lat = 0;
    while (!out_valid0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp.latency", lat, CH);
    held = out_sum0;
    check("bp.sum", held, e.sum);
    check("bp.cout", out_cout0, e.cout);
    for (int i = 0; i < 5; i++) begin
      in_valid0 = 1'b1; in_a = 16'h1111; in_b = 16'h2222;
      check("bp.valid_held", out_valid0, 1);
      check("bp.sum_stable", out_sum0, held);
      check("bp.in_ready_low", in_ready0, 0);
      @(posedge clk); #1;
    end
    in_valid0 = 1'b0;
    check("bp.valid_before_release", out_valid0, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.valid_drop", out_valid0, 0);
    check("bp.in_ready_back", in_ready0, 1);
    check("bp.not_accepted", busy0, 0);

    // Reset in the middle of RUN.
    in_a = 16'hFFFF; in_b = 16'hEEEE; in_sub = 1'b0; in_cin = 1'b0; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort.busy_before", busy0, 1);
    rst_n = 1'b0;
    #1;
    check("abort.out_valid", out_valid0, 0);
    check("abort.busy", busy0, 0);
    check("abort.sum", out_sum0, 0);
    check("abort.cout", out_cout0, 0);
    check("abort.ovf", out_ovf0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("abort.no_valid_in_reset", out_valid0, 0);
    rst_n = 1'b1;
    #1;
    check("abort.in_ready", in_ready0, 1);
    @(posedge clk); #1;
    do_op("after_abort", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Random streams: CHUNKS=4, then CHUNKS=1.
    stream(1'b0, 200);
    stream(1'b1, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
